// File: rtl/pipemulctl_if.sv
// rtl/pipemulctl_if.sv - EXE-stage multiply sequencer signal bundle
//
// Purpose: groups the EXE-side request (EXE_mul/cancel/a/b) and the
// sequencer response (stall/done/result/busy) into one interface.
// Ports (by modport):
//   master : drives EXE_mul, cancel, a, b;   observes stall, done, result, busy
//   slave  : observes EXE_mul, cancel, a, b; drives stall, done, result, busy
interface pipemulctl_if #(
  parameter int W = 32
);
  logic         EXE_mul;
  logic         cancel;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         stall;
  logic         done;
  logic [W-1:0] result;
  logic         busy;

  modport master (
    output EXE_mul, cancel, a, b,
    input  stall, done, result, busy
  );

  modport slave (
    input  EXE_mul, cancel, a, b,
    output stall, done, result, busy
  );
endinterface

// File: rtl/pipemulctl.sv
// rtl/pipemulctl.sv - iterative shift-add multiply sequencer for the EXE stage
//
// Purpose: latches the EXE operands, runs one add/shift step per cycle and
// holds the pipeline stalled until the low W bits of a*b are ready, then
// releases it for one cycle with done high.
// Ports:
//   clock  : single clock, all state on the rising edge
//   reset  : synchronous, active-high; drops any operation in flight
//   bus    : pipemulctl_if.slave
//            in  EXE_mul, cancel, a, b
//            out stall (combinational), done, result (registered), busy
module pipemulctl #(
  parameter int W     = 32,
  parameter bit EARLY = 1'b1,
  parameter int CW    = 6
) (
  input logic         clock,
  input logic         reset,
  pipemulctl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    p_q, p_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            finish;

  // Finishing is checked before stepping, so the BUSY cycle that detects it
  // leaves the datapath alone and only moves to DONE.
  assign finish = (cnt_q == CW'(W)) || (EARLY && (b_q == '0));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    if (bus.cancel) begin
      // Abort from any state; the datapath registers keep their values.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.EXE_mul) begin
            state_d = BUSY;
            a_d     = bus.a;
            b_d     = bus.b;
            p_d     = '0;
            cnt_d   = '0;
          end
        end
        BUSY: begin
          if (finish) begin
            state_d = DONE;
          end else begin
            if (b_q[0]) begin
              p_d = p_q + a_q;
            end
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CW'(1);
          end
        end
        // EXE_mul still names the finishing instruction here, so it is ignored.
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end

  // Combinational so the start cycle itself already freezes the front end.
  assign bus.stall  = ~bus.cancel & (((state_q == IDLE) & bus.EXE_mul) | (state_q == BUSY));
  assign bus.done   = (state_q == DONE);
  assign bus.busy   = (state_q != IDLE);
  assign bus.result = p_q;

endmodule

// File: tb/tb_pipemulctl.sv
// tb/tb_pipemulctl.sv - scoreboard bench for pipemulctl (EARLY=0 and EARLY=1 instances)
module tb_pipemulctl;

  logic clock;
  logic reset;
  int   cyc;
  int   n_tests;
  int   n_fail;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  pipemulctl_if #(.W(32)) if0 ();
  pipemulctl_if #(.W(32)) if1 ();

  pipemulctl #(.W(32), .EARLY(1'b0), .CW(6)) u_dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (if0.slave)
  );

  pipemulctl #(.W(32), .EARLY(1'b1), .CW(6)) u_dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (if1.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int n_early(input logic [31:0] bv);
    for (int i = 31; i >= 0; i--) begin
      if (bv[i]) return i + 1;
    end
    return 0;
  endfunction

  function automatic logic get_stall(input int d);
    return (d == 0) ? if0.stall : if1.stall;
  endfunction

  function automatic logic get_done(input int d);
    return (d == 0) ? if0.done : if1.done;
  endfunction

  function automatic logic get_busy(input int d);
    return (d == 0) ? if0.busy : if1.busy;
  endfunction

  function automatic logic [31:0] get_result(input int d);
    return (d == 0) ? if0.result : if1.result;
  endfunction

  task automatic set_in(input int d, input logic m, input logic c,
                        input logic [31:0] av, input logic [31:0] bv);
    if (d == 0) begin
      if0.EXE_mul = m; if0.cancel = c; if0.a = av; if0.b = bv;
    end else begin
      if1.EXE_mul = m; if1.cancel = c; if1.a = av; if1.b = bv;
    end
  endtask

  // Every done pulse must match the oldest queued expectation in value and cycle.
  task automatic mon(input int d);
    exp_t e;
    if (get_done(d)) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        chk($sformatf("spurious_done%0d", d), 1, 0);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("result%0d", d), get_result(d), e.res);
        chk($sformatf("done_cycle%0d", d), cyc, e.cyc);
        chk($sformatf("done_stall%0d", d), get_stall(d), 0);
      end
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      mon(0);
      mon(1);
    end
  end

  // Called just after a rising edge; start cycle is the current cycle.
  task automatic run(input int d, input logic [31:0] av, input logic [31:0] bv);
    int          n;
    int          sc;
    bit          got;
    exp_t        e;
    logic [31:0] prod;
    n    = (d == 0) ? 32 : n_early(bv);
    prod = av * bv;
    e.res = prod;
    e.cyc = cyc + n + 2;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    set_in(d, 1'b1, 1'b0, av, bv);
    sc  = 0;
    got = 0;
    for (int k = 0; k < n + 8; k++) begin
      @(negedge clock);
      if (k == 0) chk("busy_at_start", get_busy(d), 0);
      if (get_stall(d)) sc++;
      if (get_done(d)) begin
        got = 1;
        break;
      end
      @(posedge clock); #1;
      set_in(d, 1'b0, 1'b0, av, bv);
    end
    chk("done_seen", got, 1);
    chk("stall_cycles", sc, n + 2);
    @(negedge clock);
    chk("busy_after_done", get_busy(d), 0);
    chk("result_hold", get_result(d), prod);
    @(posedge clock); #1;
  endtask

  task automatic step(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clock); #1;
    end
  endtask

  initial begin
    exp_t e;
    int   t0;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    reset   = 1'b1;
    set_in(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_in(1, 1'b0, 1'b0, 32'd0, 32'd0);
    step(3);
    reset = 1'b0;
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      chk("rst_stall",  get_stall(d),  0);
      chk("rst_done",   get_done(d),   0);
      chk("rst_busy",   get_busy(d),   0);
      chk("rst_result", get_result(d), 0);
    end
    @(posedge clock); #1;

    // Fixed iteration count.
    run(0, 32'd7, 32'd6);

    // Early termination cases.
    run(1, 32'd5, 32'd0);
    run(1, 32'd3, 32'h8000_0000);
    run(1, 32'hFFFF_FFFD, 32'd7);
    run(1, 32'h0001_0000, 32'h0001_0000);

    // Back-to-back with EXE_mul held high across both instructions.
    t0 = cyc;
    e.res = 32'd12; e.cyc = t0 + 3 + 2;     q1.push_back(e);
    e.res = 32'd25; e.cyc = t0 + 6 + 3 + 2; q1.push_back(e);
    set_in(1, 1'b1, 1'b0, 32'd3, 32'd4);
    step(5);                                 // cycle T+5 is DONE
    set_in(1, 1'b1, 1'b0, 32'd5, 32'd5);
    step(1);                                 // T+6: second start accepted
    @(negedge clock);
    chk("b2b_stall_start", get_stall(1), 1);
    @(posedge clock); #1;
    set_in(1, 1'b0, 1'b0, 32'd5, 32'd5);
    step(7);
    chk("b2b_queue_empty", q1.size(), 0);

    // Cancel mid-operation, then restart in the following cycle.
    set_in(0, 1'b1, 1'b0, 32'd9, 32'd11);
    step(1);
    set_in(0, 1'b0, 1'b0, 32'd9, 32'd11);
    step(4);                                 // T+5
    set_in(0, 1'b0, 1'b1, 32'd9, 32'd11);
    @(negedge clock);
    chk("cancel_stall", get_stall(0), 0);
    chk("cancel_done",  get_done(0),  0);
    @(posedge clock); #1;                    // T+6
    run(0, 32'd123, 32'd456);

    // Reset mid-operation drops the multiply.
    set_in(1, 1'b1, 1'b0, 32'd3, 32'h8000_0000);
    step(1);
    set_in(1, 1'b0, 1'b0, 32'd3, 32'h8000_0000);
    step(2);                                 // T+3
    reset = 1'b1;
    step(1);                                 // T+4
    reset = 1'b0;
    @(negedge clock);
    chk("rstmid_busy",   get_busy(1),   0);
    chk("rstmid_done",   get_done(1),   0);
    chk("rstmid_result", get_result(1), 0);
    chk("rstmid_stall",  get_stall(1),  0);
    @(posedge clock); #1;

    // Random operands on both instances.
    for (int i = 0; i < 4; i++) begin
      run(0, $urandom, $urandom);
      run(1, $urandom, $urandom >> $urandom_range(0, 31));
    end

    step(3);
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
